sbox_share_ctrl: RTL

- Time-multiplexes one shared 4-lane S-box unit (32-bit in, 32-bit out, combinational, external) between two requesters:
  - the round datapath's 128-bit SubBytes;
  - the key expansion's 32-bit SubWord.
- Each request is captured, sequenced word by word through the shared S-box, reassembled, and returned with a one-cycle done pulse.
- Replaces four-fold S-box replication with a single instance, at the cost of latency.

---
 rtl/sbox_share_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/sbox_share_ctrl.sv
// sbox_share_ctrl: time-multiplexes one shared 4-lane S-box between the
// round datapath (128-bit SubBytes) and key expansion (32-bit SubWord).
// The state op runs one 32-bit word per cycle for 4 cycles. The key op
// runs for 1 cycle. Simultaneous requests are arbitrated round-robin.
module sbox_share_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic         st_start,
    input  logic [127:0] st_in,
    output logic         st_done,
    output logic [127:0] st_out,
    input  logic         kw_start,
    input  logic [31:0]  kw_in,
    output logic         kw_done,
    output logic [31:0]  kw_out,
    output logic [31:0]  sbox_in,
    input  logic [31:0]  sbox_out,
    output logic         busy,
    output logic         ovf
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN_ST = 2'd1,
        S_RUN_KW = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [CNT_W-1:0]     r_k;
    logic                 r_st_pend;
    logic                 r_kw_pend;
    logic                 r_last_kw;      // 0: last tie went to STATE, 1: to KEY
    logic [127:0]         r_st_in;
    logic [WORD_W-1:0]    r_kw_in;
    logic [127:0]         r_st_out;
    logic [WORD_W-1:0]    r_kw_out;
    logic                 r_st_done;
    logic                 r_kw_done;
    logic                 r_ovf;

    logic                 w_st_acc;
    logic                 w_kw_acc;
    logic                 w_st_vis;
    logic                 w_kw_vis;
    logic                 w_final;
    logic                 w_grant_pt;
    logic                 w_grant_st;
    logic                 w_grant_kw;
    logic                 w_tie;
    logic [WORD_W-1:0]    w_sbox_in;

    // A start is taken only when its requester is neither pending nor running
    assign w_st_acc   = st_start & ~r_st_pend & (r_state != S_RUN_ST);
    assign w_kw_acc   = kw_start & ~r_kw_pend & (r_state != S_RUN_KW);
    assign w_st_vis   = r_st_pend | w_st_acc;
    assign w_kw_vis   = r_kw_pend | w_kw_acc;
    assign w_final    = ((r_state == S_RUN_ST) && (r_k == CNT_W'(3))) ||
                        (r_state == S_RUN_KW);
    assign w_grant_pt = (r_state == S_IDLE) || w_final;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and grant decision at grant points
    always_comb begin
        w_next     = r_state;
        w_grant_st = 1'b0;
        w_grant_kw = 1'b0;
        w_tie      = 1'b0;
        if (w_grant_pt) begin
            if (w_st_vis && w_kw_vis) begin
                w_tie      = 1'b1;
                w_grant_kw = ~r_last_kw;
                w_grant_st = r_last_kw;
            end else begin
                w_grant_st = w_st_vis;
                w_grant_kw = w_kw_vis;
            end
            if (w_grant_st) begin
                w_next = S_RUN_ST;
            end else if (w_grant_kw) begin
                w_next = S_RUN_KW;
            end else begin
                w_next = S_IDLE;
            end
        end
    end

    // Shared S-box input selection per state
    always_comb begin
        w_sbox_in = '0;
        case (r_state)
            S_RUN_ST: w_sbox_in = r_st_in[{r_k, 5'b00000} +: WORD_W];
            S_RUN_KW: w_sbox_in = r_kw_in;
            default:  w_sbox_in = '0;
        endcase
    end

    // Request capture, arbitration bookkeeping, result assembly and pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_k       <= '0;
            r_st_pend <= 1'b0;
            r_kw_pend <= 1'b0;
            r_last_kw <= 1'b0;
            r_st_in   <= '0;
            r_kw_in   <= '0;
            r_st_out  <= '0;
            r_kw_out  <= '0;
            r_st_done <= 1'b0;
            r_kw_done <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            if (w_st_acc) begin
                r_st_in <= st_in;
            end
            if (w_kw_acc) begin
                r_kw_in <= kw_in;
            end
            r_st_pend <= w_st_vis & ~w_grant_st;
            r_kw_pend <= w_kw_vis & ~w_grant_kw;
            if (w_tie) begin
                r_last_kw <= w_grant_kw;
            end
            if (r_state == S_RUN_ST) begin
                r_k <= r_k + CNT_W'(1);
                r_st_out[{r_k, 5'b00000} +: WORD_W] <= sbox_out;
            end else begin
                r_k <= '0;
            end
            if (r_state == S_RUN_KW) begin
                r_kw_out <= sbox_out;
            end
            r_st_done <= (r_state == S_RUN_ST) && (r_k == CNT_W'(3));
            r_kw_done <= (r_state == S_RUN_KW);
            r_ovf     <= (st_start & ~w_st_acc) | (kw_start & ~w_kw_acc);
        end
    end

    assign sbox_in = w_sbox_in;
    assign st_out  = r_st_out;
    assign kw_out  = r_kw_out;
    assign st_done = r_st_done;
    assign kw_done = r_kw_done;
    assign ovf     = r_ovf;
    assign busy    = (r_state != S_IDLE);

endmodule
